// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmit FSM states and 8N1 framing values.
// No logic; imported by the transmit arbiter and its sub-blocks.
package uart_pkg;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE_LVL  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority grant: first asserted request after ptr, wrapping.
// Zero latency; no state, the caller owns the pointer and decides when it advances.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_vld
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = IW'((int'(ptr) + off) % NREQ);
         if (!gnt_vld && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
            gnt_vld   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 UART transmit line; start bit one strobe after the IDLE handshake.
// Back-pressure via one-hot req_ready, open only in IDLE or on the STOP-bit strobe.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DATA_BITS = UART_DATA_BITS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clk_bps,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*DATA_BITS-1:0] req_data,
   output logic [NREQ-1:0]           req_ready,
   output logic                      txd,
   output logic                      busy,
   output logic [$clog2(NREQ)-1:0]   grant_id
);

   localparam int         IW       = $clog2(NREQ);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   uart_state_e          state_q,  state_d;
   logic [DATA_BITS-1:0] shreg_q,  shreg_d;
   logic [2:0]           bitcnt_q, bitcnt_d;
   logic [IW-1:0]        ptr_q,    ptr_d;
   logic [IW-1:0]        gid_q,    gid_d;
   logic                 txd_q,    txd_d;

   logic [NREQ-1:0]      gnt;
   logic [IW-1:0]        gnt_idx;
   logic                 gnt_vld;
   logic                 hs_win;
   logic                 hs;
   logic [DATA_BITS-1:0] lane;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // Ready is held low during reset so nothing is accepted that the FSM would lose.
   assign hs_win    = rst_n & ((state_q == IDLE) | ((state_q == STOP) & clk_bps));
   assign req_ready = gnt & {NREQ{hs_win}};
   assign hs        = hs_win & gnt_vld;

   always_comb begin
      lane = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) lane = req_data[i*DATA_BITS +: DATA_BITS];
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      ptr_d    = ptr_q;
      gid_d    = gid_q;
      txd_d    = txd_q;

      if (hs) begin
         shreg_d = lane;
         gid_d   = gnt_idx;
         ptr_d   = gnt_idx;
      end

      unique case (state_q)
         IDLE: begin
            txd_d = UART_IDLE_LVL;
            // A strobe coinciding with this handshake is deliberately not used.
            if (hs) state_d = ARM;
         end
         ARM: begin
            if (clk_bps) begin
               txd_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (clk_bps) begin
               txd_d    = shreg_q[0];
               bitcnt_d = '0;
               state_d  = DATA;
            end
         end
         DATA: begin
            if (clk_bps) begin
               if (bitcnt_q == LAST_BIT) begin
                  txd_d   = UART_IDLE_LVL;
                  state_d = STOP;
               end else begin
                  shreg_d  = shreg_q >> 1;
                  txd_d    = shreg_q[1];
                  bitcnt_d = bitcnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (clk_bps) begin
               if (hs) begin
                  txd_d   = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = UART_IDLE_LVL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         ptr_q    <= IW'(NREQ - 1);
         gid_q    <= '0;
         txd_q    <= UART_IDLE_LVL;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         ptr_q    <= ptr_d;
         gid_q    <= gid_d;
         txd_q    <= txd_d;
      end
   end

   assign txd      = txd_q;
   assign busy     = (state_q != IDLE);
   assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4 requesters, bit strobe one cycle in every 16.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clk_bps;
   logic [NREQ-1:0] req_valid;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0] req_ready;
   logic            txd;
   logic            busy;
   logic [1:0]      grant_id;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic [NREQ-1:0] drop_mask;
   logic [NREQ-1:0] rdy_acc;
   int hs_idx[$];
   int hs_cyc[$];

   uart_tx_arbiter #(.NREQ(NREQ), .DATA_BITS(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk_bps   (clk_bps),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .txd       (txd),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: sample handshakes at negedge, then update inputs 1ns after the edge.
   task automatic tick();
      logic [NREQ-1:0] hs;
      @(negedge clk);
      hs      = req_valid & req_ready;
      rdy_acc = rdy_acc | req_ready;
      @(posedge clk);
      cyc++;
      #1;
      if (hs != '0) begin
         chk("ready_onehot", $countones(hs), 1);
         for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
               hs_idx.push_back(i);
               hs_cyc.push_back(cyc);
            end
         end
         req_valid = req_valid & ~(hs & drop_mask);
      end
      // Strobe edges are exactly the multiples of 16.
      clk_bps = ((cyc + 1) % 16 == 0);
   endtask

   task automatic wait_fall(input string tag, output int fall_at);
      int n;
      n = 0;
      while (txd !== 1'b0 && n < 400) begin
         tick();
         n++;
      end
      chk($sformatf("%s_start_seen", tag), txd === 1'b0, 1);
      fall_at = cyc;
   endtask

   task automatic frame_body(input string tag, input logic [7:0] data, input int id);
      repeat (8) tick();
      chk($sformatf("%s_start", tag), txd, 0);
      chk($sformatf("%s_gid", tag), grant_id, id);
      chk($sformatf("%s_busy", tag), busy, 1);
      for (int b = 0; b < 8; b++) begin
         repeat (16) tick();
         chk($sformatf("%s_bit%0d", tag, b), txd, data[b]);
      end
      repeat (16) tick();
      chk($sformatf("%s_stop", tag), txd, 1);
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] data, input int id,
                               output int fall_at);
      wait_fall(tag, fall_at);
      frame_body(tag, data, id);
   endtask

   task automatic clear_log();
      hs_idx.delete();
      hs_cyc.delete();
   endtask

   initial begin
      int f1, f4, fa, fb;
      int fr[4];
      int h;
      int n;
      logic txd_min;

      rst_n     = 1'b0;
      req_valid = '1;
      req_data  = '0;
      drop_mask = '1;
      rdy_acc   = '0;
      clk_bps   = 1'b0;

      // Reset values, with every requester asserting valid.
      repeat (3) tick();
      chk("rst_ready", rdy_acc, 0);
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_gid", grant_id, 0);
      req_valid = '0;
      rst_n     = 1'b1;
      tick();

      // Single byte 0xA5 from requester 0.
      clear_log();
      req_data[7:0] = 8'hA5;
      req_valid     = 4'b0001;
      expect_frame("a5", 8'hA5, 0, f1);
      chk("a5_hs_count", hs_cyc.size(), 1);
      h = (hs_cyc.size() > 0) ? hs_cyc[0] : 0;
      chk("a5_latency", f1, ((h / 16) + 1) * 16);
      repeat (7) tick();
      chk("a5_busy_in_stop", busy, 1);
      tick();
      chk("a5_busy_fall", busy, 0);
      chk("a5_idle_txd", txd, 1);

      // All four valid right after reset: order 0,1,2,3, back-to-back.
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      clear_log();
      req_data  = {8'hF0, 8'h5A, 8'h81, 8'h3C};
      req_valid = 4'b1111;
      expect_frame("all0", 8'h3C, 0, fr[0]);
      expect_frame("all1", 8'h81, 1, fr[1]);
      expect_frame("all2", 8'h5A, 2, fr[2]);
      expect_frame("all3", 8'hF0, 3, fr[3]);
      for (int k = 1; k < 4; k++) chk($sformatf("all_gap%0d", k), fr[k] - fr[k-1], 160);
      chk("all_hs_count", hs_idx.size(), 4);
      for (int k = 0; k < 4 && k < hs_idx.size(); k++) chk($sformatf("all_order%0d", k), hs_idx[k], k);
      repeat (8) tick();
      chk("all_busy_fall", busy, 0);

      // Requester 2 held, requester 1 pulsed: 2,1,2.
      clear_log();
      req_data[23:16] = 8'h96;
      req_data[15:8]  = 8'h0F;
      drop_mask = 4'b0010;
      req_valid = 4'b0100;
      tick();
      req_valid[1] = 1'b1;
      expect_frame("alt0", 8'h96, 2, fa);
      expect_frame("alt1", 8'h0F, 1, fb);
      chk("alt_gap", fb - fa, 160);
      wait_fall("alt2", fa);
      req_valid[2] = 1'b0;
      frame_body("alt2", 8'h96, 2);
      chk("alt_gap2", fa - fb, 160);
      chk("alt_hs_count", hs_idx.size(), 3);
      if (hs_idx.size() == 3) begin
         chk("alt_order0", hs_idx[0], 2);
         chk("alt_order1", hs_idx[1], 1);
         chk("alt_order2", hs_idx[2], 2);
      end
      repeat (8) tick();
      chk("alt_busy_fall", busy, 0);

      // Handshake on a strobe cycle while IDLE: start bit 16 edges later.
      drop_mask = '1;
      n = 0;
      while (clk_bps !== 1'b1 && n < 32) begin
         tick();
         n++;
      end
      clear_log();
      req_data[7:0] = 8'h5A;
      req_valid     = 4'b0001;
      expect_frame("strb", 8'h5A, 0, f4);
      chk("strb_hs_count", hs_cyc.size(), 1);
      chk("strb_hs_on_strobe", (hs_cyc.size() > 0) ? (hs_cyc[0] % 16) : -1, 0);
      chk("strb_latency", (hs_cyc.size() > 0) ? (f4 - hs_cyc[0]) : -1, 16);
      repeat (8) tick();

      // Valid dropped and data changed during ARM: latched byte still sent, no ready until STOP.
      clear_log();
      req_data[31:24] = 8'hC3;
      req_data[15:8]  = 8'h77;
      req_valid       = 4'b1000;
      tick();
      req_data[31:24] = 8'h00;
      req_valid       = 4'b0010;
      rdy_acc         = '0;
      expect_frame("arm0", 8'hC3, 3, fa);
      chk("arm_no_ready", rdy_acc, 0);
      expect_frame("arm1", 8'h77, 1, fb);
      chk("arm_gap", fb - fa, 160);
      repeat (8) tick();
      chk("arm_busy_fall", busy, 0);

      // Reset pulse during data bit 4 drops the frame; arbitration restarts at requester 0.
      clear_log();
      req_data[7:0] = 8'h0F;
      req_valid     = 4'b0001;
      wait_fall("rst", fa);
      repeat (8) tick();
      chk("rst_mid_start", txd, 0);
      repeat (80) tick();
      chk("rst_mid_bit4", txd, 0);
      chk("rst_mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_txd", txd, 1);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_gid", grant_id, 0);
      tick();
      rst_n   = 1'b1;
      txd_min = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         txd_min = txd_min & txd;
      end
      chk("rst_no_resend", txd_min, 1);
      chk("rst_idle_busy", busy, 0);
      clear_log();
      req_data[7:0]  = 8'hE7;
      req_data[15:8] = 8'h18;
      req_valid      = 4'b0011;
      expect_frame("rst_next", 8'hE7, 0, fa);
      chk("rst_next_hs_count", hs_idx.size(), 1);
      chk("rst_next_first", (hs_idx.size() > 0) ? hs_idx[0] : -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
